// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-driven hazard and forwarding controller that sits beside the ID stage.
// Define HAZARD_FORWARD_EN for EX operand forwarding; otherwise every in-flight match stalls.
module pipe_hazard_ctrl #(
    parameter int REG_AW         = 5,
    parameter int DEPTH          = 3,
    parameter int ALU_FWD_STAGE  = 2,
    parameter int LOAD_FWD_STAGE = 3,
    localparam int FW            = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_use_i,
    input  logic              id_rs2_use_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              if_flush_o,
    output logic [FW-1:0]     fwd_a_o,
    output logic [FW-1:0]     fwd_b_o
);

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Without a bypass path a result is only visible once its producer has left stage DEPTH.
    localparam int ALU_NEED  = FWD_EN ? ALU_FWD_STAGE  : DEPTH + 2;
    localparam int LOAD_NEED = FWD_EN ? LOAD_FWD_STAGE : DEPTH + 2;

    logic [DEPTH:1]    r_sb_vld;
    logic [DEPTH:1]    r_sb_rw;
    logic [DEPTH:1]    r_sb_mr;
    logic [REG_AW-1:0] r_sb_rd [1:DEPTH];
    logic              w_stall;
    logic              w_issue;

    function automatic logic f_hazard(input logic [REG_AW-1:0] src, input logic en);
        logic hit;
        logic haz;
        hit = 1'b0;
        haz = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!hit && en && (src != '0) && r_sb_vld[k] && r_sb_rw[k] && (r_sb_rd[k] == src)) begin
                hit = 1'b1;
                haz = (k + 1) < (r_sb_mr[k] ? LOAD_NEED : ALU_NEED);
            end
        end
        return haz;
    endfunction

    assign w_stall    = id_valid_i &&
                        (f_hazard(id_rs1_i, id_rs1_use_i) || f_hazard(id_rs2_i, id_rs2_use_i));
    assign w_issue    = id_valid_i && !w_stall;
    assign stall_o    = w_stall;
    assign bubble_o   = w_stall;
    assign if_flush_o = branch_taken_i && !w_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sb_vld <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_sb_vld[k] <= r_sb_vld[k-1];
            end
            r_sb_vld[1] <= w_issue;
        end
    end

    // Payload fields are qualified by r_sb_vld, so they carry no reset.
    always_ff @(posedge clk_i) begin
        for (int k = DEPTH; k >= 2; k--) begin
            r_sb_rd[k] <= r_sb_rd[k-1];
            r_sb_rw[k] <= r_sb_rw[k-1];
            r_sb_mr[k] <= r_sb_mr[k-1];
        end
        r_sb_rd[1] <= id_rd_i;
        r_sb_rw[1] <= id_regwrite_i;
        r_sb_mr[1] <= id_memread_i;
    end

`ifdef HAZARD_FORWARD_EN
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_use1;
    logic              r_ex_use2;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_stall) begin
            r_ex_rs1  <= '0;
            r_ex_rs2  <= '0;
            r_ex_use1 <= 1'b0;
            r_ex_use2 <= 1'b0;
        end else begin
            r_ex_rs1  <= id_rs1_i;
            r_ex_rs2  <= id_rs2_i;
            r_ex_use1 <= id_rs1_use_i;
            r_ex_use2 <= id_rs2_use_i;
        end
    end

    // Walk oldest to youngest so the youngest producer (smallest stage) wins; stage 1 is EX itself.
    function automatic logic [FW-1:0] f_fwd_sel(input logic [REG_AW-1:0] src, input logic en);
        logic [FW-1:0] sel;
        sel = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (en && (src != '0) && r_sb_vld[k] && r_sb_rw[k] && (r_sb_rd[k] == src)) begin
                sel = FW'(k);
            end
        end
        return sel;
    endfunction

    assign fwd_a_o = f_fwd_sel(r_ex_rs1, r_ex_use1);
    assign fwd_b_o = f_fwd_sel(r_ex_rs2, r_ex_use2);
`else
    assign fwd_a_o = '0;
    assign fwd_b_o = '0;
`endif

endmodule
